half_subtractor: RTL and testbench
==================================

HALF_SUBTRACTOR -- requirements
Module: half_subtractor

Interface
REQ-001 Parameter WIDTH, default 1: number of independent half-subtractor bit slices.
REQ-002 Parameter CNT_W, default 16: width of the borrow event counter.
REQ-003 The design SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: synchronous active-high reset.
REQ-006 Port in_valid, input, 1 bit: operand qualifier; a/b sampled only when high.
REQ-007 Port a, input, WIDTH bits: minuend, one bit per slice.
REQ-008 Port b, input, WIDTH bits: subtrahend, one bit per slice.
REQ-009 Port diff, output, WIDTH bits: registered difference per slice.
REQ-010 Port borrow, output, WIDTH bits: registered borrow-out per slice.
REQ-011 Port out_valid, output, 1 bit: high for the cycle(s) diff/borrow hold a newly computed result.
REQ-012 Port borrow_any, output, 1 bit: registered OR-reduction of borrow.
REQ-013 Port borrow_cnt, output, CNT_W bits: count of accepted operations with at least one slice borrowing.

Function
REQ-014 Per slice i: diff[i] SHALL equal a[i] XOR b[i].
REQ-015 Per slice i: borrow[i] SHALL equal (NOT a[i]) AND b[i].
REQ-016 Slices SHALL be independent; no borrow propagates between slices.
REQ-017 Latency SHALL be exactly one clock: operands accepted at edge N appear on diff/borrow after edge N.
REQ-018 out_valid SHALL be in_valid delayed by one cycle (registered copy).
REQ-019 When in_valid is low, diff, borrow and borrow_any SHALL hold their previous values.
REQ-020 borrow_any SHALL update with the same timing as borrow and equal OR of the new borrow vector.
REQ-021 borrow_cnt SHALL increment by 1 on each accepted operation whose computed borrow vector is non-zero.
REQ-022 borrow_cnt SHALL saturate at all-ones; further borrow events leave it unchanged.
REQ-023 Back-to-back in_valid SHALL be supported at one operation per cycle, no stalls, no backpressure.
REQ-024 No combinational path SHALL exist from any input to any output.

Reset
REQ-025 When rst is high at a rising edge, diff, borrow, out_valid, borrow_any and borrow_cnt SHALL all become 0.
REQ-026 rst SHALL take priority over in_valid; an operand presented in the reset cycle is discarded.
REQ-027 The first operation accepted after reset deasserts SHALL produce out_valid one cycle later with normal results.
REQ-028 Reset asserted mid-stream SHALL clear borrow_cnt to 0 even if saturated.

Verification
REQ-029 WIDTH=1, in_valid=1, a=1,b=1 -> next cycle diff=0, borrow=0, borrow_any=0, out_valid=1, borrow_cnt unchanged.
REQ-030 WIDTH=1, a=1,b=0 -> diff=1, borrow=0; a=0,b=1 -> diff=1, borrow=1, borrow_cnt +1; a=0,b=0 -> diff=0, borrow=0.
REQ-031 WIDTH=4, a=4'b0101, b=4'b0011 -> diff=4'b0110, borrow=4'b0010, borrow_any=1.
REQ-032 in_valid pulse with a=0,b=1 followed by in_valid=0 and changing a/b -> outputs hold diff=1, borrow=1; out_valid high for one cycle only.
REQ-033 CNT_W=2, four consecutive borrow-producing operations -> borrow_cnt 1,2,3,3 (saturates).
REQ-034 rst=1 together with in_valid=1, a=0,b=1 -> next cycle all outputs 0, borrow_cnt=0, out_valid=0.

Source files
------------

// File: rtl/half_subtractor.sv
// rtl/half_subtractor.sv - registered multi-slice half subtractor with borrow event counter
module half_subtractor #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] diff,
   output logic [WIDTH-1:0] borrow,
   output logic             out_valid,
   output logic             borrow_any,
   output logic [CNT_W-1:0] borrow_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Per-slice combinational results; slices never interact.
   logic [WIDTH-1:0] w_diff;
   logic [WIDTH-1:0] w_borrow;
   logic             w_borrow_any;
   logic             w_cnt_sat;

   logic [WIDTH-1:0] r_diff;
   logic [WIDTH-1:0] r_borrow;
   logic             r_valid;
   logic             r_borrow_any;
   logic [CNT_W-1:0] r_borrow_cnt;

   assign w_diff       = a ^ b;
   assign w_borrow     = ~a & b;
   assign w_borrow_any = |w_borrow;
   assign w_cnt_sat    = &r_borrow_cnt;

   // Capture results only for qualified operands; otherwise hold the last result.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_diff       <= '0;
         r_borrow     <= '0;
         r_borrow_any <= 1'b0;
      end else if (in_valid) begin
         r_diff       <= w_diff;
         r_borrow     <= w_borrow;
         r_borrow_any <= w_borrow_any;
      end
   end

   // out_valid is a one-cycle delayed copy of in_valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
      end else begin
         r_valid <= in_valid;
      end
   end

   // Count accepted operations that borrowed in any slice, sticking at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_borrow_cnt <= '0;
      end else if (in_valid && w_borrow_any && !w_cnt_sat) begin
         r_borrow_cnt <= r_borrow_cnt + CNT_ONE;
      end
   end

   assign diff       = r_diff;
   assign borrow     = r_borrow;
   assign out_valid  = r_valid;
   assign borrow_any = r_borrow_any;
   assign borrow_cnt = r_borrow_cnt;

endmodule

// File: tb/tb_half_subtractor.sv
// tb/tb_half_subtractor.sv - self-checking bench for half_subtractor (WIDTH=1/CNT_W=2 and WIDTH=4/CNT_W=3)
module tb_half_subtractor;

   logic       clk = 1'b0;
   logic       rst;

   logic       in_valid1;
   logic [0:0] a1, b1, diff1, borrow1;
   logic       out_valid1, borrow_any1;
   logic [1:0] borrow_cnt1;

   logic       in_valid4;
   logic [3:0] a4, b4, diff4, borrow4;
   logic       out_valid4, borrow_any4;
   logic [2:0] borrow_cnt4;

   int assert_cnt = 0;
   int fail_cnt   = 0;

   // Reference model state for each instance
   int m_diff1, m_bor1, m_any1, m_val1, m_cnt1;
   int m_diff4, m_bor4, m_any4, m_val4, m_cnt4;

   half_subtractor #(.WIDTH(1), .CNT_W(2)) u_dut1 (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid1),
      .a          (a1),
      .b          (b1),
      .diff       (diff1),
      .borrow     (borrow1),
      .out_valid  (out_valid1),
      .borrow_any (borrow_any1),
      .borrow_cnt (borrow_cnt1)
   );

   half_subtractor #(.WIDTH(4), .CNT_W(3)) u_dut4 (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid4),
      .a          (a4),
      .b          (b4),
      .diff       (diff4),
      .borrow     (borrow4),
      .out_valid  (out_valid4),
      .borrow_any (borrow_any4),
      .borrow_cnt (borrow_cnt4)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      assert_cnt++;
      assert (obs === exp) else begin
         fail_cnt++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Bit-wise subtraction a-b per slice using plain integer arithmetic.
   task automatic model_slices(input int w, input int av, input int bv,
                               output int d, output int bo);
      d  = 0;
      bo = 0;
      for (int i = 0; i < w; i++) begin
         int x;
         x = ((av >> i) & 1) - ((bv >> i) & 1);
         if (x < 0) bo += (1 << i);
         d += ((x + 2) % 2) << i;
      end
   endtask

   task automatic model_step(input logic r, input logic v, input int w, input int cmax,
                             input int av, input int bv,
                             inout int md, inout int mb, inout int ma,
                             inout int mv, inout int mc);
      int d, bo;
      if (r) begin
         md = 0; mb = 0; ma = 0; mv = 0; mc = 0;
      end else begin
         mv = v;
         if (v) begin
            model_slices(w, av, bv, d, bo);
            md = d;
            mb = bo;
            ma = (bo != 0) ? 1 : 0;
            if (bo != 0 && mc < cmax) mc = mc + 1;
         end
      end
   endtask

   task automatic step(input logic r,
                       input logic v1, input int av1, input int bv1,
                       input logic v4, input int av4, input int bv4);
      rst       = r;
      in_valid1 = v1;
      a1        = av1[0:0];
      b1        = bv1[0:0];
      in_valid4 = v4;
      a4        = av4[3:0];
      b4        = bv4[3:0];
      @(posedge clk);
      #1;
      model_step(r, v1, 1, 3, av1, bv1, m_diff1, m_bor1, m_any1, m_val1, m_cnt1);
      model_step(r, v4, 4, 7, av4, bv4, m_diff4, m_bor4, m_any4, m_val4, m_cnt4);
      check("w1_diff",       int'(diff1),       m_diff1);
      check("w1_borrow",     int'(borrow1),     m_bor1);
      check("w1_borrow_any", int'(borrow_any1), m_any1);
      check("w1_out_valid",  int'(out_valid1),  m_val1);
      check("w1_borrow_cnt", int'(borrow_cnt1), m_cnt1);
      check("w4_diff",       int'(diff4),       m_diff4);
      check("w4_borrow",     int'(borrow4),     m_bor4);
      check("w4_borrow_any", int'(borrow_any4), m_any4);
      check("w4_out_valid",  int'(out_valid4),  m_val4);
      check("w4_borrow_cnt", int'(borrow_cnt4), m_cnt4);
   endtask

   initial begin
      rst = 1'b1; in_valid1 = 1'b0; a1 = '0; b1 = '0;
      in_valid4 = 1'b0; a4 = '0; b4 = '0;
      m_diff1 = 0; m_bor1 = 0; m_any1 = 0; m_val1 = 0; m_cnt1 = 0;
      m_diff4 = 0; m_bor4 = 0; m_any4 = 0; m_val4 = 0; m_cnt4 = 0;
      @(negedge clk);

      // Reset state
      step(1, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      check("reset_cnt1", int'(borrow_cnt1), 0);
      check("reset_valid1", int'(out_valid1), 0);

      // First op after reset: 1-1, and the 4-bit example 0101-0011
      step(0, 1, 1, 1, 1, 4'b0101, 4'b0011);
      check("a1b1_diff", int'(diff1), 0);
      check("a1b1_cnt", int'(borrow_cnt1), 0);
      check("w4_ex_diff", int'(diff4), 4'b0110);
      check("w4_ex_borrow", int'(borrow4), 4'b0010);
      check("w4_ex_any", int'(borrow_any4), 1);

      // Remaining single-bit truth table
      step(0, 1, 1, 0, 0, 0, 0);
      check("a1b0_diff", int'(diff1), 1);
      step(0, 1, 0, 1, 0, 0, 0);
      check("a0b1_borrow", int'(borrow1), 1);
      check("a0b1_cnt", int'(borrow_cnt1), 1);
      step(0, 1, 0, 0, 0, 0, 0);

      // Single valid pulse then hold with changing operands
      step(0, 1, 0, 1, 1, 4'b0000, 4'b1111);
      step(0, 0, 1, 0, 0, 4'b1111, 4'b0000);
      check("hold_diff", int'(diff1), 1);
      check("hold_borrow", int'(borrow1), 1);
      check("hold_valid_low", int'(out_valid1), 0);
      step(0, 0, 1, 1, 0, 4'b1010, 4'b0101);

      // Counter saturation on the 2-bit counter
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 1, 1, 0, 1);
      check("sat_cnt_1", int'(borrow_cnt1), 1);
      step(0, 1, 0, 1, 1, 0, 2);
      check("sat_cnt_2", int'(borrow_cnt1), 2);
      step(0, 1, 0, 1, 1, 0, 4);
      check("sat_cnt_3", int'(borrow_cnt1), 3);
      step(0, 1, 0, 1, 1, 0, 8);
      check("sat_cnt_4", int'(borrow_cnt1), 3);
      step(0, 1, 0, 1, 1, 1, 3);

      // Mid-stream reset clears a saturated counter; operand in reset cycle is discarded
      step(1, 1, 0, 1, 1, 0, 15);
      check("rst_sat_cnt1", int'(borrow_cnt1), 0);
      check("rst_op_diff1", int'(diff1), 0);
      check("rst_op_valid1", int'(out_valid1), 0);
      step(0, 1, 0, 1, 1, 3, 12);

      // Randomized stream with occasional reset
      for (int n = 0; n < 400; n++) begin
         step(($urandom_range(0, 29) == 0),
              $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 15));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end

endmodule
